bit_serializer: RTL and testbench

- Parametrised parallel-to-serial converter. Loads a WIDTH-bit word through a valid/ready handshake and emits len bits, one per accepted cycle, on a valid/ready serial port.
- Serialises a word one bit at a time, counting through its bits. Adds programmable length, runtime bit order, output back-pressure, a last-bit flag and a one-word holding buffer, so consecutive words stream with no gap.
- Sits between the microwave datapath word registers and any bit-serial consumer.

---
 rtl/bit_serializer.sv | 127 ++++++++++++
 tb/tb_bit_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with programmable length, runtime bit order,
// back-pressure and a one-word holding buffer so consecutive words stream gap-free.
module bit_serializer #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_lsb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;
  logic             r_lsb, w_lsb_next;
  logic [WIDTH-1:0] r_pdata, w_pdata_next;
  logic [LEN_W-1:0] r_plen, w_plen_next;
  logic             r_plsb, w_plsb_next;
  logic             r_pvalid, w_pvalid_next;

  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_in_aligned;
  logic             w_accept;
  logic             w_xfer;
  logic             w_direct;

  assign w_len_eff = (in_len == '0 || in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;
  assign w_shamt   = LEN_W'(WIDTH) - w_len_eff;
  // MSB-first words are left-aligned so the first bit always sits at WIDTH-1.
  assign w_in_aligned = in_lsb_first ? in_data : (in_data << w_shamt);

  assign in_ready  = !r_pvalid;
  assign out_valid = (r_state == StShift);
  assign out_bit   = out_valid & (r_lsb ? r_data[0] : r_data[WIDTH-1]);
  assign out_last  = out_valid & (r_cnt == LEN_W'(1));
  assign busy      = out_valid | r_pvalid;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;

  always_comb begin
    w_state_next  = r_state;
    w_data_next   = r_data;
    w_cnt_next    = r_cnt;
    w_lsb_next    = r_lsb;
    w_pdata_next  = r_pdata;
    w_plen_next   = r_plen;
    w_plsb_next   = r_plsb;
    w_pvalid_next = r_pvalid;
    w_direct      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_direct = 1'b1;
        end
      end
      StShift: begin
        if (w_xfer) begin
          if (r_cnt > LEN_W'(1)) begin
            w_data_next = r_lsb ? (r_data >> 1) : (r_data << 1);
            w_cnt_next  = r_cnt - LEN_W'(1);
          end else if (r_pvalid) begin
            w_data_next   = r_pdata;
            w_cnt_next    = r_plen;
            w_lsb_next    = r_plsb;
            w_pvalid_next = 1'b0;
          end else if (w_accept) begin
            w_direct = 1'b1;
          end else begin
            w_state_next = StIdle;
            w_data_next  = '0;
            w_cnt_next   = '0;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_direct) begin
      w_state_next = StShift;
      w_data_next  = w_in_aligned;
      w_cnt_next   = w_len_eff;
      w_lsb_next   = in_lsb_first;
    end else if (w_accept) begin
      w_pdata_next  = w_in_aligned;
      w_plen_next   = w_len_eff;
      w_plsb_next   = in_lsb_first;
      w_pvalid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_data   <= '0;
      r_cnt    <= '0;
      r_lsb    <= 1'b0;
      r_pdata  <= '0;
      r_plen   <= '0;
      r_plsb   <= 1'b0;
      r_pvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_data   <= w_data_next;
      r_cnt    <= w_cnt_next;
      r_lsb    <= w_lsb_next;
      r_pdata  <= w_pdata_next;
      r_plen   <= w_plen_next;
      r_plsb   <= w_plsb_next;
      r_pvalid <= w_pvalid_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: word/bit queue model checked every cycle,
// directed literal sequences from the test plan, then randomized traffic.
module tb_bit_serializer;
  localparam int WIDTH = 20;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_lsb_first;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model: pending bits in emission order, and remaining bit count per word in flight.
  bit exp_bits[$];
  int word_rem[$];
  bit rx_bits[$];
  bit rx_last[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_len      (in_len),
    .in_lsb_first(in_lsb_first),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                           input logic lsb);
    int n;
    n = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
    for (int i = 0; i < n; i++) exp_bits.push_back(lsb ? d[i] : d[n-1-i]);
    word_rem.push_back(n);
  endtask

  // Called in the low phase: check outputs against the model, then advance one edge.
  task automatic step();
    bit m_valid, m_ready, acc, xf;
    m_valid = word_rem.size() > 0;
    m_ready = word_rem.size() < 2;
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_valid);
    if (m_valid) begin
      chk("out_bit", out_bit, exp_bits[0]);
      chk("out_last", out_last, word_rem[0] == 1);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    acc = in_valid && m_ready;
    xf  = m_valid && out_ready;
    if (xf) begin
      rx_bits.push_back(out_bit);
      rx_last.push_back(out_last);
    end
    @(posedge clk);
    if (xf) begin
      void'(exp_bits.pop_front());
      word_rem[0] = word_rem[0] - 1;
      if (word_rem[0] == 0) void'(word_rem.pop_front());
    end
    if (acc) push_word(in_data, in_len, in_lsb_first);
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l, input logic lsb);
    bit done;
    done = 1'b0;
    in_data      = d;
    in_len       = l;
    in_lsb_first = lsb;
    in_valid     = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      done = word_rem.size() < 2;
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word never accepted, expected acceptance within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int k;
    k = 0;
    in_valid = 1'b0;
    while (word_rem.size() > 0 && k < 500) begin
      out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step();
      k++;
    end
    if (word_rem.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words left, expected 0", word_rem.size());
    end
    out_ready = 1'b1;
    step();
  endtask

  // Sequence bit i is pat[i]; out_last expected where lmask[i] is set.
  task automatic check_rx(input string name, input logic [31:0] pat, input int n,
                          input logic [31:0] lmask);
    chk({name, "_count"}, rx_bits.size(), n);
    for (int i = 0; i < n && i < rx_bits.size(); i++) begin
      chk({name, "_bit"}, rx_bits[i], pat[i]);
      chk({name, "_last"}, rx_last[i], lmask[i]);
    end
    rx_bits.delete();
    rx_last.delete();
  endtask

  initial begin
    reset        = 1'b0;
    in_data      = '0;
    in_len       = '0;
    in_lsb_first = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();

    send(20'hA5F0C, 5'd0, 1'b1);
    drain(1'b0);
    check_rx("full_lsb", 32'hA5F0C, 20, 32'h1 << 19);

    send(20'h00009, 5'd4, 1'b0);
    drain(1'b0);
    check_rx("short_msb", 32'h9, 4, 32'h8);

    send(20'h00006, 5'd3, 1'b1);
    send(20'h00003, 5'd3, 1'b1);
    drain(1'b0);
    check_rx("b2b", 32'h1E, 6, 32'h24);

    send(20'h000C3, 5'd8, 1'b1);
    drain(1'b1);
    check_rx("backpressure", 32'hC3, 8, 32'h80);

    send(20'hFFFFF, 5'd1, 1'b1);
    drain(1'b0);
    check_rx("len1", 32'h1, 1, 32'h1);

    send(20'h12345, 5'd25, 1'b1);
    drain(1'b0);
    check_rx("len25", 32'h12345, 20, 32'h1 << 19);

    // Asynchronous reset during the 7th bit.
    send(20'hFFFFF, 5'd0, 1'b1);
    for (int k = 0; k < 6; k++) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_out_bit", out_bit, 0);
    chk("arst_in_ready", in_ready, 1);
    exp_bits.delete();
    word_rem.delete();
    rx_bits.delete();
    rx_last.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    send(20'h00003, 5'd20, 1'b0);
    drain(1'b0);
    check_rx("post_reset", 32'hC0000, 20, 32'h1 << 19);

    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom % 3) != 0;
      in_data      = WIDTH'($urandom);
      in_len       = LEN_W'($urandom_range(0, 31));
      in_lsb_first = $urandom % 2;
      out_ready    = ($urandom % 10) < 7;
      step();
    end
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
